// File: rtl/tsg_frame_packer_pkg.sv
// Shared types for the test_sig_gen stream stages: framing FSM states and the beat payload
// carried through register slices.
package tsg_pkg;

    localparam int unsigned TSG_DATA_W = 128;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tsg_pack_state_t;

    typedef struct packed {
        logic [TSG_DATA_W-1:0] data;
        logic                  last;
        logic                  user;
    } tsg_beat_t;

endpackage

// File: rtl/tsg_frame_packer_if.sv
// AXI4-Stream beat bundle with first/last sideband; master drives payload, slave drives ready.
interface tsg_frame_packer_if #(
    parameter int unsigned DATA_W = tsg_pkg::TSG_DATA_W
) ();

    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);

endinterface

// File: rtl/tsg_frame_packer_skid.sv
// Two-entry register slice for tsg_beat_t: one cycle of latency, full throughput,
// and upstream ready depends only on local state.
module axis_skid_buf
    import tsg_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_s_valid,
    output logic      o_s_ready,
    input  tsg_beat_t i_s_beat,
    output logic      o_m_valid,
    input  logic      i_m_ready,
    output tsg_beat_t o_m_beat
);

    tsg_beat_t r_head;
    tsg_beat_t r_spill;
    logic      r_head_vld;
    logic      r_spill_vld;
    logic      w_push;
    logic      w_pop;

    assign o_s_ready = !r_spill_vld;
    assign w_push    = i_s_valid && !r_spill_vld;
    assign w_pop     = r_head_vld && i_m_ready;

    // Head register faces downstream; spill only fills while the head is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head      <= '0;
            r_spill     <= '0;
            r_head_vld  <= 1'b0;
            r_spill_vld <= 1'b0;
        end else if (!r_head_vld || w_pop) begin
            if (r_spill_vld) begin
                r_head      <= r_spill;
                r_head_vld  <= 1'b1;
                r_spill_vld <= 1'b0;
            end else begin
                r_head_vld <= w_push;
                if (w_push) begin
                    r_head <= i_s_beat;
                end
            end
        end else if (w_push) begin
            r_spill     <= i_s_beat;
            r_spill_vld <= 1'b1;
        end
    end

    assign o_m_valid = r_head_vld;
    assign o_m_beat  = r_head;

endmodule

// File: rtl/tsg_frame_packer.sv
// Cuts the continuous test_sig_gen sample stream into frames of frame_len beats,
// tagging the first beat with tuser and the last with tlast; enable gates whole frames.
module tsg_frame_packer
    import tsg_pkg::*;
#(
    parameter int unsigned DATA_W = TSG_DATA_W,
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned FCNT_W = 32
) (
    input  logic                axis_aclk,
    input  logic                axis_aresetn,
    input  logic                enable,
    input  logic [LEN_W-1:0]    frame_len,
    tsg_frame_packer_if.slave   s_axis,
    tsg_frame_packer_if.master  m_axis,
    output logic [FCNT_W-1:0]   frame_cnt,
    output logic                busy
);

    tsg_pack_state_t   r_state;
    tsg_pack_state_t   w_state_nxt;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_beat;
    logic [FCNT_W-1:0] r_frame_cnt;
    logic              r_live;

    logic [DATA_W-1:0] w_s_data;
    logic [LEN_W-1:0]  w_len_new;
    logic              w_is_last;
    logic              w_push;
    logic              w_acc;
    logic              w_s_tready;
    logic              w_skid_ready;
    logic              w_out_valid;
    tsg_beat_t         w_in_beat;
    tsg_beat_t         w_out_beat;
    logic              w_unused_ok;

    assign w_s_data    = s_axis.tdata;
    assign w_unused_ok = &{1'b0, s_axis.tlast, s_axis.tuser};

    // A zero length would never produce tlast, so it is promoted to single-beat frames.
    assign w_len_new = (frame_len == '0) ? LEN_W'(1) : frame_len;
    assign w_is_last = (r_beat == (r_len - LEN_W'(1)));
    assign w_acc     = w_push && w_skid_ready;

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (enable) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_acc && w_is_last && !enable) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // IDLE swallows beats so the generator free-runs; RUN forwards into the slice.
    always_comb begin
        w_s_tready     = 1'b0;
        w_push         = 1'b0;
        w_in_beat      = '0;
        w_in_beat.data = w_s_data;
        w_in_beat.user = (r_beat == '0);
        w_in_beat.last = w_is_last;
        unique case (r_state)
            ST_IDLE: w_s_tready = r_live;
            ST_RUN: begin
                w_s_tready = r_live && w_skid_ready;
                w_push     = r_live && s_axis.tvalid;
            end
            default: w_s_tready = 1'b0;
        endcase
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_len       <= LEN_W'(1);
            r_beat      <= '0;
            r_frame_cnt <= '0;
            r_live      <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (r_state == ST_IDLE) begin
                if (enable) begin
                    r_len  <= w_len_new;
                    r_beat <= '0;
                end
            end else if (w_acc) begin
                if (w_is_last) begin
                    r_beat      <= '0;
                    r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
                    if (enable) begin
                        r_len <= w_len_new;
                    end
                end else begin
                    r_beat <= r_beat + LEN_W'(1);
                end
            end
        end
    end

    axis_skid_buf u_skid (
        .clk       (axis_aclk),
        .rst_n     (axis_aresetn),
        .i_s_valid (w_push),
        .o_s_ready (w_skid_ready),
        .i_s_beat  (w_in_beat),
        .o_m_valid (w_out_valid),
        .i_m_ready (m_axis.tready),
        .o_m_beat  (w_out_beat)
    );

    assign s_axis.tready = w_s_tready;
    assign m_axis.tvalid = w_out_valid;
    assign m_axis.tdata  = w_out_beat.data;
    assign m_axis.tlast  = w_out_beat.last;
    assign m_axis.tuser  = w_out_beat.user;
    assign frame_cnt     = r_frame_cnt;
    assign busy          = (r_state == ST_RUN);

endmodule

// File: tb/tb_tsg_frame_packer.sv
// Directed bench for tsg_frame_packer: framing, zero length, enable drop, random backpressure,
// mid-frame length change and asynchronous reset mid-frame.
module tb_tsg_frame_packer;
    import tsg_pkg::*;

    localparam int unsigned DW = 128;
    localparam int unsigned LW = 16;
    localparam int unsigned FW = 32;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          enable    = 1'b0;
    logic [LW-1:0] frame_len = '0;
    logic [FW-1:0] frame_cnt;
    logic          busy;

    logic tb_ready  = 1'b1;
    logic rnd_mode  = 1'b0;
    logic chk_hs    = 1'b0;

    int n_total     = 0;
    int n_bad       = 0;
    int n_acc_run   = 0;
    int n_out_total = 0;

    tsg_beat_t q_out[$];
    tsg_beat_t cur_beat;
    tsg_beat_t prev_beat;
    logic      prev_stall = 1'b0;

    tsg_frame_packer_if #(.DATA_W(DW)) s_if ();
    tsg_frame_packer_if #(.DATA_W(DW)) m_if ();

    assign m_if.tready = tb_ready;

    tsg_frame_packer #(.DATA_W(DW), .LEN_W(LW), .FCNT_W(FW)) dut (
        .axis_aclk    (clk),
        .axis_aresetn (rst_n),
        .enable       (enable),
        .frame_len    (frame_len),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .frame_cnt    (frame_cnt),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        tb_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Handshakes are sampled on the falling edge; they complete on the following rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (chk_hs) begin
                if (busy) chk("s_tready_held", 128'(s_if.tready), 128'((n_acc_run - n_out_total) < 2));
                if (prev_stall) begin
                    chk("stall_valid", 128'(m_if.tvalid), 128'(1));
                    chk("stall_data", m_if.tdata, prev_beat.data);
                    chk("stall_flags", 128'({m_if.tlast, m_if.tuser}), 128'({prev_beat.last, prev_beat.user}));
                end
            end
            cur_beat.data = m_if.tdata;
            cur_beat.last = m_if.tlast;
            cur_beat.user = m_if.tuser;
            prev_stall    = m_if.tvalid && !m_if.tready;
            prev_beat     = cur_beat;
            if (m_if.tvalid && m_if.tready) begin
                q_out.push_back(cur_beat);
                n_out_total++;
            end
            if (busy && s_if.tvalid && s_if.tready) n_acc_run++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beats(input int first, input int n, input logic [127:0] base,
                              input int drop_at, input int chg_at, input logic [LW-1:0] chg_len);
        for (int i = first; i < n; i++) begin
            int guard;
            guard = 0;
            if (i == drop_at) enable = 1'b0;
            if (i == chg_at)  frame_len = chg_len;
            s_if.tvalid = 1'b1;
            s_if.tdata  = base + 128'(i);
            while (!s_if.tready && guard < 100) begin
                step();
                guard++;
            end
            if (guard >= 100) begin
                n_total++;
                n_bad++;
                $error("FAIL send_timeout beat=%0d observed=stalled expected=accepted", i);
                break;
            end
            step();
        end
        s_if.tvalid = 1'b0;
    endtask

    task automatic wait_out(input int n, input string tag);
        int guard;
        guard = 0;
        while (q_out.size() < n && guard < 300) begin
            step();
            guard++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk(tag, 128'(q_out.size()), 128'(n));
    endtask

    // First frame has length la, every later frame lb.
    task automatic chk_seq(input int n, input logic [127:0] base, input int la, input int lb, input string tag);
        for (int i = 0; i < n && i < q_out.size(); i++) begin
            int k;
            int l;
            if (i < la) begin
                k = i;
                l = la;
            end else begin
                k = (i - la) % lb;
                l = lb;
            end
            chk($sformatf("%s_data%0d", tag, i), q_out[i].data, base + 128'(i));
            chk($sformatf("%s_user%0d", tag, i), 128'(q_out[i].user), 128'(k == 0));
            chk($sformatf("%s_last%0d", tag, i), 128'(q_out[i].last), 128'(k == l - 1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] b1, b2, b3, b4, b5, b6;
        b1 = 128'h1000;
        b2 = 128'h2000;
        b3 = 128'h3000;
        b4 = {64'hDEAD_BEEF_0000_0000, 64'h4000};
        b5 = 128'h5000;
        b6 = 128'h6000;

        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        enable      = 1'b1;
        frame_len   = 16'd4;

        repeat (10) @(posedge clk);
        #1;
        chk("rst_tvalid", 128'(m_if.tvalid), 128'(0));
        chk("rst_tlast", 128'(m_if.tlast), 128'(0));
        chk("rst_tuser", 128'(m_if.tuser), 128'(0));
        chk("rst_tdata", m_if.tdata, 128'(0));
        chk("rst_fcnt", 128'(frame_cnt), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_s_tready", 128'(s_if.tready), 128'(0));
        rst_n = 1'b1;

        // 1: three 4-beat frames, one-cycle latency
        step();
        chk("t1_busy", 128'(busy), 128'(1));
        send_beats(0, 1, b1, -1, -1, '0);
        chk("t1_lat_valid", 128'(m_if.tvalid), 128'(1));
        chk("t1_lat_data", m_if.tdata, b1);
        chk("t1_lat_user", 128'(m_if.tuser), 128'(1));
        chk("t1_lat_last", 128'(m_if.tlast), 128'(0));
        send_beats(1, 12, b1, 11, -1, '0);
        wait_out(12, "t1_count");
        chk_seq(12, b1, 4, 4, "t1");
        chk("t1_fcnt", 128'(frame_cnt), 128'(3));
        chk("t1_idle", 128'(busy), 128'(0));

        // 2: zero length acts as single-beat frames
        q_out.delete();
        frame_len = 16'd0;
        enable    = 1'b1;
        step();
        send_beats(0, 3, b2, 2, -1, '0);
        wait_out(3, "t2_count");
        chk_seq(3, b2, 1, 1, "t2");
        chk("t2_fcnt", 128'(frame_cnt), 128'(6));

        // 3: enable dropped mid-frame, frame completes, then idle discards
        q_out.delete();
        frame_len = 16'd8;
        enable    = 1'b1;
        step();
        send_beats(0, 8, b3, 3, -1, '0);
        wait_out(8, "t3_count");
        chk_seq(8, b3, 8, 8, "t3");
        chk("t3_fcnt", 128'(frame_cnt), 128'(7));
        chk("t3_idle", 128'(busy), 128'(0));
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t3_discard_rdy%0d", i), 128'(s_if.tready), 128'(1));
            s_if.tvalid = 1'b1;
            s_if.tdata  = 128'h3F00 + 128'(i);
            step();
        end
        s_if.tvalid = 1'b0;
        repeat (4) step();
        chk("t3_discard_cnt", 128'(q_out.size()), 128'(8));
        chk("t3_discard_fcnt", 128'(frame_cnt), 128'(7));

        // 4: 16-beat frames under random downstream backpressure
        q_out.delete();
        frame_len = 16'd16;
        enable    = 1'b1;
        rnd_mode  = 1'b1;
        chk_hs    = 1'b1;
        step();
        send_beats(0, 32, b4, 31, -1, '0);
        wait_out(32, "t4_count");
        chk_hs   = 1'b0;
        rnd_mode = 1'b0;
        step();
        chk_seq(32, b4, 16, 16, "t4");
        chk("t4_fcnt", 128'(frame_cnt), 128'(9));

        // 5: length change mid-frame applies from the next frame
        q_out.delete();
        frame_len = 16'd4;
        enable    = 1'b1;
        step();
        send_beats(0, 10, b5, 9, 2, 16'd6);
        wait_out(10, "t5_count");
        chk_seq(10, b5, 4, 6, "t5");
        chk("t5_fcnt", 128'(frame_cnt), 128'(11));

        // 6: asynchronous reset in the middle of an 8-beat frame
        q_out.delete();
        frame_len = 16'd8;
        enable    = 1'b1;
        step();
        send_beats(0, 5, b6, -1, -1, '0);
        s_if.tvalid = 1'b1;
        s_if.tdata  = b6 + 128'(5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_tvalid", 128'(m_if.tvalid), 128'(0));
        chk("t6_rst_fcnt", 128'(frame_cnt), 128'(0));
        chk("t6_rst_busy", 128'(busy), 128'(0));
        chk("t6_rst_s_tready", 128'(s_if.tready), 128'(0));
        s_if.tvalid = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        q_out.delete();
        step();
        chk("t6_busy", 128'(busy), 128'(1));
        send_beats(0, 8, b6 + 128'h100, 7, -1, '0);
        wait_out(8, "t6_count");
        chk_seq(8, b6 + 128'h100, 8, 8, "t6");
        chk("t6_fcnt", 128'(frame_cnt), 128'(1));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
